// File: rtl/dds_voice_pkg.sv
// Shared definitions for the single-voice DDS tone generator.
// Holds the envelope state encoding and the PCM/envelope rail values.
package dds_voice_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD0   = 3'd1,
    S_LOAD1   = 3'd2,
    S_ATTACK  = 3'd3,
    S_SUSTAIN = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [7:0] PCM_MID = 8'd128;
  localparam logic [7:0] ENV_MAX = 8'd255;

endpackage

// File: rtl/dds_voice_pwm_dac.sv
// 1-bit PWM DAC: a free-running 8-bit counter is compared against the PCM
// sample, giving a duty cycle of pcm/256 over a 256-clock period.
module pwm_dac (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic [7:0] i_pcm,
  output logic       o_pwm
);

  logic [7:0] cnt_q, cnt_d;
  logic       pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    pwm_d = (cnt_q < i_pcm);
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/dds_voice.sv
// Single-voice tone generator: note-table handshake, phase accumulator,
// linear attack/release envelope with volume, 8-bit PCM and PWM outputs.
module dds_voice
  import dds_voice_pkg::*;
#(
  parameter int ACC_W      = 20,
  parameter int SAMPLE_DIV = 85,
  parameter int ATK_STEP   = 4,
  parameter int REL_STEP   = 1
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic        i_note_on,
  input  logic        i_note_off,
  input  logic [6:0]  i_noteNum,
  input  logic [3:0]  i_volume,
  output logic [6:0]  o_noteNum,
  input  logic [15:0] i_dds_inc,
  output logic [7:0]  o_pcm,
  output logic        o_pcm_valid,
  output logic        o_busy,
  output logic        o_pwm
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  state_t             state_q, state_d;
  logic [6:0]         note_q, note_d;
  logic [ACC_W-1:0]   phase_q, phase_d;
  logic [15:0]        inc_q, inc_d;
  logic [7:0]         env_q, env_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pend_q, pend_d;
  logic [7:0]         pcm_q, pcm_d;
  logic               pcm_valid_q, pcm_valid_d;

  logic               tick;
  logic [8:0]         env_sum;
  logic [7:0]         env_up, env_dn;
  logic [11:0]        prod;
  logic [7:0]         amp;

  always_comb begin
    state_d     = state_q;
    note_d      = note_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    env_d       = env_q;
    pend_d      = pend_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;

    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    env_sum = {1'b0, env_q} + 9'(ATK_STEP);
    env_up  = env_sum[8] ? ENV_MAX : env_sum[7:0];
    env_dn  = (env_q > 8'(REL_STEP)) ? env_q - 8'(REL_STEP) : 8'd0;
    prod    = 12'(env_q) * 12'(i_volume);
    amp     = 8'(prod >> 5);

    // The sample is taken from phase/env before this tick's own update.
    if (tick) begin
      pcm_valid_d = 1'b1;
      if (state_q == S_IDLE)          pcm_d = PCM_MID;
      else if (phase_q[ACC_W-1])      pcm_d = PCM_MID + amp;
      else                            pcm_d = PCM_MID - amp;
    end

    if (i_note_on) begin
      note_d  = i_noteNum;
      phase_d = '0;
      pend_d  = 1'b0;
      state_d = S_LOAD0;
    end else begin
      if (tick && (state_q == S_ATTACK || state_q == S_SUSTAIN || state_q == S_RELEASE))
        phase_d = phase_q + ACC_W'(inc_q);
      case (state_q)
        S_LOAD0: begin
          state_d = S_LOAD1;
          if (i_note_off) pend_d = 1'b1;
        end
        S_LOAD1: begin
          inc_d   = i_dds_inc;
          state_d = (pend_q || i_note_off) ? S_RELEASE : S_ATTACK;
          pend_d  = 1'b0;
        end
        S_ATTACK: begin
          if (tick) begin
            env_d = env_up;
            if (env_up == ENV_MAX) state_d = S_SUSTAIN;
          end
          if (i_note_off) state_d = S_RELEASE;
        end
        S_SUSTAIN: begin
          if (i_note_off) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (tick) begin
            env_d = env_dn;
            if (env_dn == 8'd0) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q     <= S_IDLE;
      note_q      <= '0;
      phase_q     <= '0;
      inc_q       <= '0;
      env_q       <= '0;
      div_q       <= '0;
      pend_q      <= 1'b0;
      pcm_q       <= PCM_MID;
      pcm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      env_q       <= env_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  pwm_dac u_pwm_dac (
    .i_clk (i_clk),
    .i_res (i_res),
    .i_pcm (pcm_q),
    .o_pwm (o_pwm)
  );

  assign o_noteNum   = note_q;
  assign o_pcm       = pcm_q;
  assign o_pcm_valid = pcm_valid_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_voice.sv
// Bench for dds_voice: a registered note-table model, a sample-level
// behavioural voice model, directed scenarios and a randomized soak.
module tb_dds_voice;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [6:0]  note_num = '0;
  logic [3:0]  volume = '0;
  logic [6:0]  o_note;
  logic [15:0] dds_inc = '0;
  logic [7:0]  o_pcm;
  logic        o_pcm_valid, o_busy, o_pwm;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  localparam int MI = 0, ML = 1, MA = 2, MS = 3, MR = 4;
  int m_div, m_stage, m_load, m_pend, m_env, m_phase, m_inc, m_note;
  int m_pcm, m_valid, m_cnt, m_pwm;

  dds_voice dut (
    .i_clk       (clk),
    .i_res       (res),
    .i_note_on   (note_on),
    .i_note_off  (note_off),
    .i_noteNum   (note_num),
    .i_volume    (volume),
    .o_noteNum   (o_note),
    .i_dds_inc   (dds_inc),
    .o_pcm       (o_pcm),
    .o_pcm_valid (o_pcm_valid),
    .o_busy      (o_busy),
    .o_pwm       (o_pwm)
  );

  always #5 clk = ~clk;

  function automatic int table_inc(input int n);
    case (n)
      69:      return 1640;
      60:      return 975;
      127:     return 46767;
      default: return 200 + n * 97;
    endcase
  endfunction

  // Note table sits beside the voice with one clock of latency.
  always @(posedge clk) dds_inc <= 16'(table_inc(int'(o_note)));

  task automatic model_step();
    int tick, amp, old_stage;
    if (res) begin
      m_div = 0; m_stage = MI; m_load = 0; m_pend = 0; m_env = 0; m_phase = 0;
      m_inc = 0; m_note = 0; m_pcm = 128; m_valid = 0; m_cnt = 0; m_pwm = 0;
      return;
    end
    tick  = (m_div == 84) ? 1 : 0;
    m_div = tick ? 0 : m_div + 1;
    m_pwm = (m_cnt < m_pcm) ? 1 : 0;
    m_cnt = (m_cnt + 1) % 256;
    m_valid = tick;
    if (tick) begin
      amp = (m_env * int'(volume)) / 32;
      if (m_stage == MI)            m_pcm = 128;
      else if (m_phase >= 524288)   m_pcm = 128 + amp;
      else                          m_pcm = 128 - amp;
    end
    old_stage = m_stage;
    if (note_on) begin
      m_note = int'(note_num); m_phase = 0; m_stage = ML; m_load = 2; m_pend = 0;
    end else if (m_stage == ML) begin
      if (m_load == 2) begin
        m_load = 1;
        if (note_off) m_pend = 1;
      end else begin
        m_inc   = table_inc(m_note);
        m_stage = (m_pend != 0 || note_off) ? MR : MA;
        m_pend  = 0;
      end
    end else if (m_stage != MI) begin
      if (tick) begin
        m_phase = (m_phase + m_inc) % 1048576;
        if (m_stage == MA) begin
          m_env = (m_env + 4 > 255) ? 255 : m_env + 4;
          if (m_env == 255) m_stage = MS;
        end else if (m_stage == MR) begin
          m_env = (m_env - 1 < 0) ? 0 : m_env - 1;
          if (m_env == 0) m_stage = MI;
        end
      end
      if (note_off && (old_stage == MA || old_stage == MS)) m_stage = MR;
    end
  endtask

  always @(posedge clk) model_step();

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      n_checks++;
      if (int'(o_pcm) != m_pcm || int'(o_pcm_valid) != m_valid ||
          o_busy != (m_stage != MI) || int'(o_pwm) != m_pwm || int'(o_note) != m_note) begin
        n_errors++;
        $display("[TB] FAIL model_cmp t=%0t pcm=%0d/%0d valid=%0d/%0d busy=%0d/%0d pwm=%0d/%0d note=%0d/%0d (dut/model)",
                 $time, o_pcm, m_pcm, o_pcm_valid, m_valid, o_busy, (m_stage != MI),
                 o_pwm, m_pwm, o_note, m_note);
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic apply_stimulus(input bit on, input bit off, input int n);
    @(negedge clk);
    note_on = on; note_off = off; note_num = 7'(n);
    @(negedge clk);
    note_on = 1'b0; note_off = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_pcm_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check_output({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pcm"}, int'(o_pcm), 128);
    check_output({tag, "_valid"}, int'(o_pcm_valid), 0);
    check_output({tag, "_busy"}, int'(o_busy), 0);
    check_output({tag, "_pwm"}, int'(o_pwm), 0);
    check_output({tag, "_note"}, int'(o_note), 0);
  endtask

  initial begin
    bit ok;
    int first_high, cnt, guard;
    res = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    res = 1'b0;
    check_reset_outputs("reset");

    // Note 69 at full volume: attack, sustain rails, polarity flip.
    volume = 4'd15;
    apply_stimulus(1'b1, 1'b0, 69);
    first_high = -1;
    for (int k = 1; k <= 340; k++) begin
      wait_valid("tone69", ok);
      if (!ok) break;
      if (k == 70) begin
        n_checks++;
        if (o_pcm != 8'd247 && o_pcm != 8'd9) begin
          n_errors++;
          $display("[TB] FAIL sustain_rail actual=%0d required=247 or 9", o_pcm);
        end
      end
      if (first_high < 0 && o_pcm > 8'd128) first_high = k;
    end
    check_range("first_high_sample", first_high, 320, 323);
    check_output("busy_sustain", int'(o_busy), 1);

    // Release from 255 takes exactly 255 ticks.
    apply_stimulus(1'b0, 1'b1, 0);
    cnt = 0;
    guard = 0;
    while (o_busy && guard < 30000) begin
      @(negedge clk);
      guard++;
      if (o_pcm_valid) cnt++;
    end
    check_output("release_ticks", cnt, 255);
    wait_valid("idle_sample", ok);
    if (ok) check_output("idle_pcm", int'(o_pcm), 128);

    // note_off one clock after note_on: load completes, then release.
    @(negedge clk);
    note_on = 1'b1; note_num = 7'd50;
    @(negedge clk);
    note_on = 1'b0; note_off = 1'b1;
    @(negedge clk);
    note_off = 1'b0;
    check_output("early_off_busy", int'(o_busy), 1);
    check_output("early_off_note", int'(o_note), 50);
    guard = 0;
    while (o_busy && guard < 300) begin @(negedge clk); guard++; end
    check_output("early_off_idle", int'(o_busy), 0);

    // Simultaneous on/off: on wins; retrigger at env=100 keeps env.
    apply_stimulus(1'b1, 1'b1, 64);
    guard = 0;
    while (m_env != 100 && guard < 5000) begin @(negedge clk); guard++; end
    check_output("reach_env100", m_env, 100);
    apply_stimulus(1'b1, 1'b0, 60);
    wait_valid("retrig", ok);
    if (ok) check_output("retrig_pcm", int'(o_pcm), 82);
    check_output("retrig_note", int'(o_note), 60);

    // Reset mid-sustain, then a high note that wraps the phase quickly.
    guard = 0;
    while (m_stage != MS && guard < 10000) begin @(negedge clk); guard++; end
    check_output("reach_sustain", int'(o_busy), 1);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check_reset_outputs("midnote_reset");
    apply_stimulus(1'b1, 1'b0, 127);
    repeat (4000) @(negedge clk);

    // Randomized soak.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      note_on  = ($urandom_range(599) == 0);
      note_off = ($urandom_range(399) == 0);
      note_num = 7'($urandom_range(127));
      if ($urandom_range(199) == 0) volume = 4'($urandom_range(15));
      res = ($urandom_range(4999) == 0);
    end
    @(negedge clk);
    note_on = 1'b0; note_off = 1'b0; res = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
